// File: rtl/mem_access_stage_if.sv
// rtl/mem_access_stage_if.sv - ready/ack memory port between the MEM stage and data memory
interface mem_access_stage_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  mem_req;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [3:0]            mem_be;
    logic                  mem_ack;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - MEM-stage load/store unit with byte enables, stall and misalign detect
module mem_access_stage #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  MemReadM,
    input  logic                  MemWriteM,
    input  logic [2:0]            funct3M,
    input  logic [DATA_WIDTH-1:0] ALUResultM,
    input  logic [DATA_WIDTH-1:0] WriteDataM,
    output logic [DATA_WIDTH-1:0] ReadData,
    output logic                  StallM,
    output logic                  MisalignM,
    mem_access_stage_if.master    mem
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                state_q, state_d;
    logic                  we_q, we_d;
    logic [DATA_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [3:0]            be_q, be_d;
    logic [2:0]            f3_q, f3_d;
    logic [1:0]            off_q, off_d;

    logic                  access;
    logic                  illegal;
    logic [1:0]            off_in;
    logic [3:0]            be_new;
    logic [DATA_WIDTH-1:0] wdata_new;
    logic [7:0]            rbyte;
    logic [15:0]           rhalf;
    logic [DATA_WIDTH-1:0] load_ext;
    logic                  stall;
    logic                  misalign;

    assign access = MemReadM | MemWriteM;
    assign off_in = ALUResultM[1:0];

    // funct3[1:0] selects width; 011 and 11x are not RV32I load/store encodings
    assign illegal = (funct3M == 3'b011) || (funct3M[2:1] == 2'b11)
                  || ((funct3M[1:0] == 2'b01) && off_in[0])
                  || ((funct3M[1:0] == 2'b10) && (off_in != 2'b00));

    always_comb begin
        be_new    = 4'b1111;
        wdata_new = WriteDataM;
        case (funct3M[1:0])
            2'b00: begin
                be_new    = 4'b0001 << off_in;
                wdata_new = {4{WriteDataM[7:0]}};
            end
            2'b01: begin
                be_new    = off_in[1] ? 4'b1100 : 4'b0011;
                wdata_new = {2{WriteDataM[15:0]}};
            end
            default: begin
                be_new    = 4'b1111;
                wdata_new = WriteDataM;
            end
        endcase
    end

    // Lane selection uses the offset captured at accept, not the live address
    assign rbyte = mem.mem_rdata[{off_q, 3'b000} +: 8];
    assign rhalf = mem.mem_rdata[{off_q[1], 4'b0000} +: 16];

    always_comb begin
        case (f3_q)
            3'b000:  load_ext = {{(DATA_WIDTH-8){rbyte[7]}}, rbyte};
            3'b100:  load_ext = {{(DATA_WIDTH-8){1'b0}}, rbyte};
            3'b001:  load_ext = {{(DATA_WIDTH-16){rhalf[15]}}, rhalf};
            3'b101:  load_ext = {{(DATA_WIDTH-16){1'b0}}, rhalf};
            default: load_ext = mem.mem_rdata;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        be_d     = be_q;
        f3_d     = f3_q;
        off_d    = off_q;
        stall    = 1'b0;
        misalign = 1'b0;
        case (state_q)
            IDLE: begin
                if (access) begin
                    if (illegal) begin
                        misalign = 1'b1;
                        if (!MemWriteM) rdata_d = '0;
                    end else begin
                        stall   = 1'b1;
                        we_d    = MemWriteM;
                        addr_d  = {ALUResultM[DATA_WIDTH-1:2], 2'b00};
                        wdata_d = wdata_new;
                        be_d    = be_new;
                        f3_d    = funct3M;
                        off_d   = off_in;
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                stall = 1'b1;
                if (mem.mem_ack) begin
                    if (!we_q) rdata_d = load_ext;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            be_q    <= 4'b0000;
            f3_q    <= 3'b000;
            off_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            be_q    <= be_d;
            f3_q    <= f3_d;
            off_q   <= off_d;
        end
    end

    // Stall/misalign are combinational off live inputs; force them low while reset is held
    assign StallM        = stall & ~rst;
    assign MisalignM     = misalign & ~rst;
    assign ReadData      = rdata_q;
    assign mem.mem_req   = (state_q == BUSY);
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;
    assign mem.mem_be    = be_q;
endmodule
